result_monitor: RTL and testbench
=================================

Name: result_monitor

Overview:
- Parametrised, synthesizable self-check block that snoops the CPU memory write path. It replaces fixed-time, single-address end-of-test checks.
- Holds a table of up to N_CHECKS expected (address, data, mask) results and records the last value written to each checked address.
- A test ends either on a write to a programmable done address or on a cycle timeout. The block then reports PASS/FAIL, the first failing entry, and the elapsed cycle count.
- Sits beside top.mem in SuiteA/SuiteB benches; the bench reads its status instead of peeking RAM.

Parameters:
- ADDR_W, 16, width of the snooped address bus.
- DATA_W, 8, width of the snooped data bus.
- N_CHECKS, 4, number of check table entries (1..16).
- IDX_W, 2, index width; must equal clog2(N_CHECKS), minimum 1.
- CNT_W, 16, width of the cycle counter and timeout.

Ports:
- ph2  in  1  single clock; all state updates on rising edge.
- resetb  in  1  asynchronous active-low reset.
- cfg_we  in  1  write one check-table entry.
- cfg_idx  in  IDX_W  entry index.
- cfg_addr  in  ADDR_W  checked address.
- cfg_data  in  DATA_W  expected value.
- cfg_mask  in  DATA_W  compare mask (1 = bit compared).
- cfg_en  in  1  entry valid bit written with the entry.
- done_addr  in  ADDR_W  write here = end of test (static while running).
- timeout  in  CNT_W  cycle limit; 0 = no timeout.
- start  in  1  one-cycle pulse, begin monitoring.
- memwrite  in  1  CPU write strobe.
- adr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- busy  out  1  monitoring in progress.
- finished  out  1  result valid (sticky until start/reset).
- pass  out  1  all enabled entries matched.
- timed_out  out  1  ended by timeout.
- fail_idx  out  IDX_W  lowest-index failing entry (0 if pass).
- cycles  out  CNT_W  cycles from start to end.

Behaviour:
- Reset (async, resetb=0): state IDLE. busy, finished, pass and timed_out are 0. fail_idx and cycles are 0. All entry valid/seen bits are 0; last-value registers are 0.
- States:
  - IDLE -> RUN on start.
  - RUN -> EVAL on a done write or on timeout.
  - EVAL -> DONE after one cycle.
  - DONE -> RUN on start.
- cfg_we is honoured only in IDLE or DONE; it is ignored in RUN/EVAL. Each entry's seen bit clears on start.
- RUN:
  - busy=1; cycles increments each cycle and saturates at all-ones.
  - Each cycle with memwrite=1, every valid entry whose addr==adr captures wdata and sets seen. Several entries with the same address all capture.
  - memwrite with adr==done_addr moves to EVAL; that write's data is still captured by matching entries.
  - If timeout!=0 and cycles==timeout-1 with no done write, move to EVAL with timed_out=1.
  - A done write on the same cycle as the timeout takes priority: timed_out=0.
- EVAL: entry i fails if valid and (!seen or ((last^expected)&mask)!=0).
  - pass=1 iff no entry fails and timed_out=0.
  - fail_idx = lowest failing index.
  - An empty table (no valid entries) passes unless timed out.
  - Results register at the end of EVAL; finished rises entering DONE, so finished asserts exactly 2 cycles after the done write.
- DONE: outputs held; snooping ignored; busy=0.
- start while in RUN or EVAL restarts: seen and cycles cleared, results cleared.
- Async reset during RUN returns to IDLE immediately and discards the table.

Test Plan:
- Entry0 {adr 0x00A9, data 0xAA, mask 0xFF, en}, done_addr 0x0200. Write 0xAA to 0x00A9, then 0x01 to 0x0200 -> finished 2 cycles later, pass=1, fail_idx=0, timed_out=0.
- Same table; write 0x55 to 0x00A9 then 0xAA to 0x00A9, then done -> pass=1 (last value wins). Reversed order -> pass=0, fail_idx=0.
- 4 entries, entry2 {0x0010, 0xF0, mask 0xF0}. Write 0xF7 to 0x0010, 0xE0 to entry3's address, others correct -> pass=0, fail_idx=3 (entry2 masked match).
- timeout=100, no done write -> finished at start+101, timed_out=1, pass=0, cycles=99. Done write exactly on timeout cycle -> timed_out=0.
- Entry1 enabled but never written; done -> pass=0, fail_idx=1. Disable entry1 and rerun with start -> pass=1, cycles reset to the new count.
- resetb low mid-RUN -> busy, finished and pass drop immediately; after release the block sits in IDLE, ignores writes until start, and cfg writes succeed.

Source files
------------

// File: rtl/result_monitor.sv
// Snoops CPU memory writes, holds a table of expected results and reports the
// end-of-test verdict. States: IDLE = waiting for start | RUN = snooping, counting |
// EVAL = compare table | DONE = result held until the next start.
module result_monitor #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int N_CHECKS = 4,
    parameter int IDX_W    = 2,
    parameter int CNT_W    = 16
) (
    input  logic              ph2,
    input  logic              resetb,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [DATA_W-1:0] cfg_mask,
    input  logic              cfg_en,
    input  logic [ADDR_W-1:0] done_addr,
    input  logic [CNT_W-1:0]  timeout,
    input  logic              start,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              finished,
    output logic              pass,
    output logic              timed_out,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [CNT_W-1:0]  cycles
);

    typedef enum logic [1:0] {IDLE, RUN, EVAL, DONE} state_t;

    state_t              state;
    logic [N_CHECKS-1:0] valid;
    logic [N_CHECKS-1:0] seen;
    logic [ADDR_W-1:0]   ent_addr [N_CHECKS];
    logic [DATA_W-1:0]   ent_exp  [N_CHECKS];
    logic [DATA_W-1:0]   ent_mask [N_CHECKS];
    logic [DATA_W-1:0]   last     [N_CHECKS];
    logic                tmo;

    logic                done_wr;
    logic                tmo_hit;
    logic                any_fail;
    logic [IDX_W-1:0]    first_fail;
    logic [N_CHECKS-1:0] hit;
    logic [N_CHECKS-1:0] fails;

    always_comb begin
        done_wr    = memwrite && (adr == done_addr);
        tmo_hit    = (timeout != '0) && (cycles == timeout - CNT_W'(1));
        hit        = '0;
        fails      = '0;
        first_fail = '0;
        for (int i = 0; i < N_CHECKS; i++) begin
            hit[i]   = memwrite && valid[i] && (ent_addr[i] == adr);
            fails[i] = valid[i] && (!seen[i] || ((last[i] ^ ent_exp[i]) & ent_mask[i]) != '0);
        end
        // Scan downward so the lowest failing index is the one that sticks.
        for (int i = N_CHECKS - 1; i >= 0; i--) begin
            if (fails[i]) first_fail = IDX_W'(i);
        end
        any_fail = |fails;
    end

    always_ff @(posedge ph2 or negedge resetb) begin
        if (!resetb) begin
            state     <= IDLE;
            busy      <= 1'b0;
            finished  <= 1'b0;
            pass      <= 1'b0;
            timed_out <= 1'b0;
            fail_idx  <= '0;
            cycles    <= '0;
            tmo       <= 1'b0;
            valid     <= '0;
            seen      <= '0;
            for (int i = 0; i < N_CHECKS; i++) begin
                ent_addr[i] <= '0;
                ent_exp[i]  <= '0;
                ent_mask[i] <= '0;
                last[i]     <= '0;
            end
        end else begin
            if (cfg_we && (state == IDLE || state == DONE) && (32'(cfg_idx) < N_CHECKS)) begin
                valid[cfg_idx]    <= cfg_en;
                ent_addr[cfg_idx] <= cfg_addr;
                ent_exp[cfg_idx]  <= cfg_data;
                ent_mask[cfg_idx] <= cfg_mask;
            end
            if (start) begin
                state     <= RUN;
                busy      <= 1'b1;
                finished  <= 1'b0;
                pass      <= 1'b0;
                timed_out <= 1'b0;
                fail_idx  <= '0;
                cycles    <= '0;
                tmo       <= 1'b0;
                seen      <= '0;
            end else begin
                case (state)
                    RUN: begin
                        for (int i = 0; i < N_CHECKS; i++) begin
                            if (hit[i]) begin
                                last[i] <= wdata;
                                seen[i] <= 1'b1;
                            end
                        end
                        // A done write on the timeout cycle wins over the timeout.
                        if (done_wr) begin
                            state <= EVAL;
                            tmo   <= 1'b0;
                        end else if (tmo_hit) begin
                            state <= EVAL;
                            tmo   <= 1'b1;
                        end else if (cycles != '1) begin
                            cycles <= cycles + CNT_W'(1);
                        end
                    end
                    EVAL: begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        finished  <= 1'b1;
                        timed_out <= tmo;
                        pass      <= !any_fail && !tmo;
                        fail_idx  <= first_fail;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_result_monitor.sv
// Bench for result_monitor: directed test-plan runs plus randomized tables and write
// streams, checked against a write-replay model of the check table.
module tb_result_monitor;

    logic        ph2 = 1'b0;
    logic        resetb;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [15:0] cfg_addr = '0;
    logic [7:0]  cfg_data = '0;
    logic [7:0]  cfg_mask = '0;
    logic        cfg_en = 1'b0;
    logic [15:0] done_addr = 16'h0200;
    logic [15:0] timeout = '0;
    logic        start = 1'b0;
    logic        memwrite = 1'b0;
    logic [15:0] adr = '0;
    logic [7:0]  wdata = '0;
    logic        busy, finished, pass, timed_out;
    logic [1:0]  fail_idx;
    logic [15:0] cycles;

    result_monitor dut (
        .ph2(ph2), .resetb(resetb),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_mask(cfg_mask), .cfg_en(cfg_en), .done_addr(done_addr), .timeout(timeout),
        .start(start), .memwrite(memwrite), .adr(adr), .wdata(wdata),
        .busy(busy), .finished(finished), .pass(pass), .timed_out(timed_out),
        .fail_idx(fail_idx), .cycles(cycles)
    );

    always #5 ph2 = ~ph2;

    int total = 0;
    int bad = 0;

    // Model of the configured table
    logic        m_valid [4];
    logic [15:0] m_addr  [4];
    logic [7:0]  m_exp   [4];
    logic [7:0]  m_mask  [4];

    // Write stream for one run, one element per cycle after start
    logic        seq_we  [256];
    logic [15:0] seq_adr [256];
    logic [7:0]  seq_wd  [256];
    int          seq_len;
    bit          cfg_in_run = 0;

    task automatic tick();
        @(posedge ph2);
        #1;
    endtask

    task automatic cfg_entry(input int idx, input logic [15:0] a, input logic [7:0] d,
                             input logic [7:0] m, input logic en);
        logic [31:0] iv;
        iv = idx;
        cfg_we = 1'b1; cfg_idx = iv[1:0]; cfg_addr = a; cfg_data = d; cfg_mask = m; cfg_en = en;
        tick();
        cfg_we = 1'b0;
        m_valid[idx] = en; m_addr[idx] = a; m_exp[idx] = d; m_mask[idx] = m;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0; m_addr[i] = 0; m_exp[i] = 0; m_mask[i] = 0;
        end
    endtask

    task automatic add_wr(input logic [15:0] a, input logic [7:0] d);
        seq_we[seq_len] = 1'b1; seq_adr[seq_len] = a; seq_wd[seq_len] = d;
        seq_len++;
    endtask

    task automatic add_idle();
        seq_we[seq_len] = 1'b0; seq_adr[seq_len] = 16'h0; seq_wd[seq_len] = 8'h0;
        seq_len++;
    endtask

    // Replay the stream: find the ending cycle, apply writes up to it, judge the table.
    task automatic model_run(output bit e_pass, output int e_idx, output bit e_tmo,
                             output int e_end);
        bit          seen [4];
        logic [7:0]  last [4];
        bit          ended;
        bit          we_j;
        int          t;
        t = int'(timeout);
        for (int i = 0; i < 4; i++) begin seen[i] = 0; last[i] = 0; end
        e_end = -1; e_tmo = 0; ended = 0;
        for (int j = 0; j < 5000 && !ended; j++) begin
            we_j = (j < seq_len) && seq_we[j];
            if (we_j)
                for (int i = 0; i < 4; i++)
                    if (m_valid[i] && m_addr[i] == seq_adr[j]) begin
                        seen[i] = 1; last[i] = seq_wd[j];
                    end
            if (we_j && seq_adr[j] == done_addr) begin
                ended = 1; e_end = j; e_tmo = 0;
            end else if (t != 0 && j == t - 1) begin
                ended = 1; e_end = j; e_tmo = 1;
            end
        end
        e_idx = -1;
        for (int i = 0; i < 4; i++)
            if (e_idx < 0 && m_valid[i] && (!seen[i] || ((last[i] ^ m_exp[i]) & m_mask[i]) != 0))
                e_idx = i;
        e_pass = (e_idx < 0) && !e_tmo;
        if (e_idx < 0) e_idx = 0;
    endtask

    task automatic run_check(input string name);
        bit e_pass, e_tmo;
        int e_idx, e_end, fin_at;
        model_run(e_pass, e_idx, e_tmo, e_end);
        start = 1'b1;
        tick();
        start = 1'b0;
        fin_at = -1;
        for (int j = 0; j < 2000 && fin_at < 0; j++) begin
            if (j < seq_len) begin
                memwrite = seq_we[j]; adr = seq_adr[j]; wdata = seq_wd[j];
            end else begin
                memwrite = 1'b0; adr = 16'h0; wdata = 8'h0;
            end
            if (cfg_in_run && j == 0) begin
                cfg_we = 1'b1; cfg_idx = 2'd0; cfg_addr = 16'h0; cfg_data = 8'h0;
                cfg_mask = 8'h0; cfg_en = 1'b0;
            end
            tick();
            cfg_we = 1'b0;
            if (j == 0 && e_end > 0) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++; $display("FAIL %s busy: got %b want 1", name, busy);
                end
            end
            if (finished === 1'b1) fin_at = j;
        end
        memwrite = 1'b0;
        total++;
        if (fin_at != e_end + 1) begin
            bad++; $display("FAIL %s finish_time: got %0d want %0d", name, fin_at, e_end + 1);
        end
        total++;
        if (pass !== e_pass) begin
            bad++; $display("FAIL %s pass: got %b want %b", name, pass, e_pass);
        end
        total++;
        if (fail_idx !== 2'(e_idx)) begin
            bad++; $display("FAIL %s fail_idx: got %0d want %0d", name, fail_idx, e_idx);
        end
        total++;
        if (timed_out !== e_tmo) begin
            bad++; $display("FAIL %s timed_out: got %b want %b", name, timed_out, e_tmo);
        end
        total++;
        if (cycles !== 16'(e_end)) begin
            bad++; $display("FAIL %s cycles: got %0d want %0d", name, cycles, e_end);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL %s busy_done: got %b want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        resetb = 1'b1;
        #1 resetb = 1'b0;
        #2;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        total++; if (finished !== 1'b0)  begin bad++; $display("FAIL reset finished: got %b want 0", finished); end
        total++; if (pass !== 1'b0)      begin bad++; $display("FAIL reset pass: got %b want 0", pass); end
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL reset timed_out: got %b want 0", timed_out); end
        total++; if (fail_idx !== 2'd0)  begin bad++; $display("FAIL reset fail_idx: got %0d want 0", fail_idx); end
        total++; if (cycles !== 16'd0)   begin bad++; $display("FAIL reset cycles: got %0d want 0", cycles); end
        clear_model();
        #3 resetb = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        done_addr = 16'h0200; timeout = 16'd0;
        cfg_entry(0, 16'h00A9, 8'hAA, 8'hFF, 1'b1);
        seq_len = 0; add_wr(16'h00A9, 8'hAA); add_wr(16'h0200, 8'h01);
        run_check("basic");
        // DONE must ignore further writes and hold the verdict
        memwrite = 1'b1; adr = 16'h00A9; wdata = 8'h00; tick();
        adr = 16'h0200; tick(); memwrite = 1'b0; tick();
        total++;
        if (pass !== 1'b1 || finished !== 1'b1) begin
            bad++; $display("FAIL done_hold: got pass=%b fin=%b want 1 1", pass, finished);
        end
    endtask

    task automatic test_last_wins();
        seq_len = 0; add_wr(16'h00A9, 8'h55); add_idle(); add_wr(16'h00A9, 8'hAA);
        add_wr(16'h0200, 8'h01);
        run_check("last_wins");
        seq_len = 0; add_wr(16'h00A9, 8'hAA); add_wr(16'h00A9, 8'h55); add_wr(16'h0200, 8'h01);
        run_check("last_wins_rev");
    endtask

    task automatic test_mask();
        cfg_entry(1, 16'h0011, 8'h11, 8'hFF, 1'b1);
        cfg_entry(2, 16'h0010, 8'hF0, 8'hF0, 1'b1);
        cfg_entry(3, 16'h0012, 8'h33, 8'hFF, 1'b1);
        seq_len = 0;
        add_wr(16'h00A9, 8'hAA); add_wr(16'h0011, 8'h11); add_wr(16'h0010, 8'hF7);
        add_wr(16'h0012, 8'hE0); add_wr(16'h0200, 8'h01);
        run_check("mask");
    endtask

    task automatic test_timeout();
        clear_model();
        for (int i = 0; i < 4; i++) cfg_entry(i, 16'h0000, 8'h00, 8'h00, 1'b0);
        cfg_entry(0, 16'h00A9, 8'hAA, 8'hFF, 1'b1);
        timeout = 16'd100;
        seq_len = 0; add_wr(16'h00A9, 8'hAA);
        run_check("timeout");
        timeout = 16'd5;
        seq_len = 0; add_wr(16'h00A9, 8'hAA);
        for (int k = 0; k < 3; k++) add_idle();
        add_wr(16'h0200, 8'h01);
        run_check("done_on_timeout");
        timeout = 16'd0;
    endtask

    task automatic test_unwritten();
        cfg_entry(1, 16'h0031, 8'h00, 8'hFF, 1'b1);
        seq_len = 0; add_wr(16'h00A9, 8'hAA); add_wr(16'h0200, 8'h01);
        run_check("unwritten");
        cfg_entry(1, 16'h0031, 8'h00, 8'hFF, 1'b0);
        seq_len = 0; add_idle(); add_wr(16'h00A9, 8'hAA); add_idle(); add_idle();
        add_wr(16'h0200, 8'h01);
        run_check("disabled_rerun");
    endtask

    task automatic test_cfg_locked();
        // entry0 left unwritten; a disable attempt during RUN must not take effect
        cfg_in_run = 1;
        seq_len = 0; add_idle(); add_wr(16'h0200, 8'h01);
        run_check("cfg_locked");
        cfg_in_run = 0;
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL mid_run busy: got %b want 1", busy); end
        #2 resetb = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || finished !== 1'b0 || pass !== 1'b0) begin
            bad++; $display("FAIL mid_reset: got busy=%b fin=%b pass=%b want 0 0 0", busy, finished, pass);
        end
        clear_model();
        #1 resetb = 1'b1;
        tick();
        memwrite = 1'b1; adr = 16'h0200; wdata = 8'h01; tick(); tick(); memwrite = 1'b0; tick();
        total++;
        if (busy !== 1'b0 || finished !== 1'b0) begin
            bad++; $display("FAIL idle_ignore: got busy=%b fin=%b want 0 0", busy, finished);
        end
        cfg_entry(2, 16'h0044, 8'h5A, 8'h0F, 1'b1);
        seq_len = 0; add_wr(16'h0044, 8'hAA); add_wr(16'h0200, 8'h01);
        run_check("after_reset");
    endtask

    task automatic test_random();
        logic [15:0] pool [5];
        logic [15:0] a;
        logic [7:0]  d;
        int n;
        pool[0] = 16'h0010; pool[1] = 16'h0011; pool[2] = 16'h0012; pool[3] = 16'h0013;
        pool[4] = 16'h0200;
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < 4; i++)
                cfg_entry(i, pool[$urandom_range(0, 3)], 8'($urandom), 8'($urandom),
                          1'($urandom_range(0, 3) != 0));
            timeout = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(2, 15)) : 16'd0;
            seq_len = 0;
            n = $urandom_range(2, 12);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 4) == 0) begin
                    add_idle();
                end else begin
                    a = pool[$urandom_range(0, 3)];
                    if ($urandom_range(0, 14) == 0) a = pool[4];
                    d = 8'($urandom);
                    for (int i = 0; i < 4; i++)
                        if (m_addr[i] == a && $urandom_range(0, 9) < 7) d = m_exp[i];
                    add_wr(a, d);
                end
            end
            if (timeout == 16'd0 || $urandom_range(0, 1) == 1) add_wr(16'h0200, 8'($urandom));
            run_check($sformatf("random%0d", it));
        end
        timeout = 16'd0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_last_wins();
        test_mask();
        test_timeout();
        test_unwritten();
        test_cfg_locked();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
